fsk2_rx_demod: RTL



---
 rtl/fsk2_rx_demod_pkg.sv | 32 +++
 rtl/fsk2_zc_det.sv | 57 +++++
 rtl/fsk2_rx_demod.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fsk2_rx_demod_pkg.sv
// ============================================================================
// Module      : fsk2_rx_demod_pkg
// Description : Shared constants, FSM state encoding and a saturating
//               counter helper for the 2FSK receive demodulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsk2_rx_demod_pkg;

  // Frame geometry shared with the 2FSK transmitter
  localparam int C_SYM_CYCLES = 51;
  localparam int C_NBITS      = 16;

  // Receiver FSM encoding (matches the transmitter's state numbering)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RECV  = 2'd2
  } state_e;

  // 4-bit increment that sticks at 15 instead of wrapping
  function automatic logic [3:0] sat_inc4(input logic [3:0] cnt, input logic inc);
    if (inc && (cnt != 4'hF)) begin
      return cnt + 4'd1;
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsk2_zc_det.sv
// ============================================================================
// Module      : fsk2_zc_det
// Description : Hysteresis polarity tracker. The tracked polarity only flips
//               once the sample leaves the +/-HYST deadband, so small noise
//               around zero cannot generate crossings.
// Ports       : clk_i    - clock
//               rst_i    - synchronous active-high reset (polarity -> 0)
//               sample_i - signed two's complement sample, one per clock
//               xing_o   - high in the clock whose sample flips the polarity
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsk2_zc_det
  import fsk2_rx_demod_pkg::*;
#(
  parameter int SAMPLE_W = 32,
  parameter int HYST     = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                xing_o
);

  localparam logic signed [SAMPLE_W-1:0] HYST_P = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] HYST_N = -HYST_P;

  logic                       pol_q;
  logic                       pol_d;
  logic signed [SAMPLE_W-1:0] sample_s;

  assign sample_s = $signed(sample_i);

  always_comb begin
    pol_d = pol_q;
    if (sample_s > HYST_P) begin
      pol_d = 1'b1;
    end else if (sample_s < HYST_N) begin
      pol_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pol_q <= 1'b0;
    end else begin
      pol_q <= pol_d;
    end
  end

  // Combinational so the window-end slicer sees a crossing on its own clock
  assign xing_o = pol_d ^ pol_q;

endmodule

`default_nettype wire

// File: rtl/fsk2_rx_demod.sv
// ============================================================================
// Module      : fsk2_rx_demod
// Description : 2FSK demodulator (1 MHz = '0', 2 MHz = '1', 50 MHz samples).
//               Counts hysteresis crossings per symbol window, slices each
//               window to a bit and reassembles an NBITS word, MSB first.
// Ports       : sys_clk_i     - 50 MHz clock
//               sys_rst_i     - synchronous active-high reset
//               rx_i          - signed sample stream
//               frame_start_i - pulse; first symbol sample ALIGN_DLY clocks on
//               bit_out_o     - last sliced bit
//               bit_valid_o   - one-clock strobe with each new bit
//               data_out_o    - last complete word, held until the next one
//               data_valid_o  - one-clock strobe with each new word
//               busy_o        - FSM outside IDLE
//               err_clr_i     - clears sym_err_o   (FSK2_RX_ERR_EN only)
//               sym_err_o     - sticky bad-window flag (FSK2_RX_ERR_EN only)
// Options     : define FSK2_RX_ERR_EN to add the symbol error monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsk2_rx_demod
  import fsk2_rx_demod_pkg::*;
#(
  parameter int SAMPLE_W    = 32,
  parameter int NBITS       = C_NBITS,
  parameter int SYM_CYCLES  = C_SYM_CYCLES,
  parameter int ALIGN_DLY   = 2,
  parameter int HYST        = 1024,
  parameter int XING_THRESH = 4
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [SAMPLE_W-1:0] rx_i,
  input  logic                frame_start_i,
  output logic                bit_out_o,
  output logic                bit_valid_o,
  output logic [NBITS-1:0]    data_out_o,
  output logic                data_valid_o,
  output logic                busy_o
`ifdef FSK2_RX_ERR_EN
  ,
  input  logic                err_clr_i,
  output logic                sym_err_o
`endif
);

  localparam int SW = $clog2(SYM_CYCLES);
  localparam int BW = $clog2(NBITS);
  localparam int AW = (ALIGN_DLY > 1) ? $clog2(ALIGN_DLY) : 1;

  localparam logic [SW-1:0] SYM_LAST   = SW'(SYM_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'((ALIGN_DLY > 0) ? (ALIGN_DLY - 1) : 0);
  localparam logic [3:0]    XT         = 4'(XING_THRESH);

  state_e           state_q, state_d;
  logic [SW-1:0]    sym_cnt_q, sym_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]    align_cnt_q, align_cnt_d;
  logic [3:0]       xing_cnt_q, xing_cnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic [NBITS-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;

  logic             xing;
  logic [3:0]       xing_incl;
  logic             win_end;
  logic             last_win;
  logic             sliced_bit;

  fsk2_zc_det #(
    .SAMPLE_W (SAMPLE_W),
    .HYST     (HYST)
  ) u_zc_det (
    .clk_i    (sys_clk_i),
    .rst_i    (sys_rst_i),
    .sample_i (rx_i),
    .xing_o   (xing)
  );

  // Count seen by the slicer includes a crossing landing on the last sample
  assign xing_incl  = sat_inc4(xing_cnt_q, xing);
  assign win_end    = (state_q == RECV) && (sym_cnt_q == SYM_LAST);
  assign last_win   = win_end && (bit_cnt_q == BIT_LAST);
  assign sliced_bit = (xing_incl >= XT);

  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    align_cnt_d  = align_cnt_q;
    xing_cnt_d   = xing_cnt_q;
    shreg_d      = shreg_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // frame_start handled below
      end

      ALIGN: begin
        if (align_cnt_q == ALIGN_LAST) begin
          state_d     = RECV;
          align_cnt_d = '0;
        end else begin
          align_cnt_d = align_cnt_q + 1'b1;
        end
      end

      RECV: begin
        xing_cnt_d = xing_incl;
        sym_cnt_d  = sym_cnt_q + 1'b1;
        if (win_end) begin
          sym_cnt_d   = '0;
          xing_cnt_d  = '0;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          bit_out_d   = sliced_bit;
          bit_valid_d = 1'b1;
          shreg_d     = {shreg_q[NBITS-2:0], sliced_bit};
          if (last_win) begin
            data_out_d   = {shreg_q[NBITS-2:0], sliced_bit};
            data_valid_d = 1'b1;
            state_d      = IDLE;
            bit_cnt_d    = '0;
            shreg_d      = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A new frame_start always wins over the in-progress frame, except that a
    // frame completing in this very clock is still delivered.
    if (frame_start_i) begin
      state_d     = (ALIGN_DLY == 0) ? RECV : ALIGN;
      sym_cnt_d   = '0;
      bit_cnt_d   = '0;
      align_cnt_d = '0;
      xing_cnt_d  = '0;
      shreg_d     = '0;
      if (!last_win) begin
        bit_valid_d = 1'b0;
        bit_out_d   = bit_out_q;
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q      <= IDLE;
      sym_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      align_cnt_q  <= '0;
      xing_cnt_q   <= '0;
      shreg_q      <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      align_cnt_q  <= align_cnt_d;
      xing_cnt_q   <= xing_cnt_d;
      shreg_q      <= shreg_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bit_out_o    = bit_out_q;
  assign bit_valid_o  = bit_valid_q;
  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = (state_q != IDLE);

`ifdef FSK2_RX_ERR_EN
  logic sym_err_q;
  logic bad_win;

  // Too few crossings means no carrier; too many means noise
  assign bad_win = win_end && ((xing_incl < 4'd1) || (xing_incl > 4'd6));

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      sym_err_q <= 1'b0;
    end else if (bad_win) begin
      sym_err_q <= 1'b1;
    end else if (err_clr_i) begin
      sym_err_q <= 1'b0;
    end
  end

  assign sym_err_o = sym_err_q;
`endif

endmodule

`default_nettype wire
